// File: rtl/aib_avmm_cfg_sequencer.sv
// Avalon-MM write sequencer: walks the per-channel MAIN / PHASE register table for the AIB adapter.
// Optional readback-and-compare of every write is built when AIB_CFG_READBACK_EN is defined.
module aib_avmm_cfg_sequencer #(
    parameter int          TOTAL_CHNL_NUM = 24,
    parameter logic [31:0] MAIN_DATA0     = 32'h0000_0001,
    parameter logic [31:0] MAIN_DATA1     = 32'h0000_0100,
    parameter logic [31:0] MAIN_DATA2     = 32'h0001_0000,
    parameter logic [31:0] PHASE_DATA     = 32'h0000_0003
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_main_op,
    output logic        main_op_done,
    input  logic        start_phase_adj,
    output logic        phase_adj_done,
    output logic [16:0] avmm_address,
    output logic [31:0] avmm_writedata,
    output logic [3:0]  avmm_byteenable,
    output logic        avmm_write,
    output logic        avmm_read,
    input  logic        avmm_waitrequest,
    input  logic [31:0] avmm_readdata,
    input  logic        avmm_readdatavalid,
    output logic        cfg_error
);

    localparam logic [5:0] LAST_CHNL = 6'(TOTAL_CHNL_NUM - 1);

`ifdef AIB_CFG_READBACK_EN
    typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_RD, S_RD_WAIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WR, S_GAP} state_t;
`endif

    function automatic logic [10:0] reg_offset(input logic is_main, input logic [1:0] idx);
        if (!is_main)        return 11'h31C;
        else if (idx == 2'd0) return 11'h208;
        else if (idx == 2'd1) return 11'h20C;
        else                  return 11'h210;
    endfunction

    function automatic logic [31:0] reg_data(input logic is_main, input logic [1:0] idx);
        if (!is_main)        return PHASE_DATA;
        else if (idx == 2'd0) return MAIN_DATA0;
        else if (idx == 2'd1) return MAIN_DATA1;
        else                  return MAIN_DATA2;
    endfunction

    state_t      state_q, state_d;
    logic        op_main_q, op_main_d;
    logic [5:0]  chnl_q, chnl_d, nxt_chnl;
    logic [1:0]  reg_q, reg_d, nxt_reg;
    logic        start_main_q, start_phase_q;
    logic        main_edge, phase_edge, last_entry;
    logic        write_d, main_done_d, phase_done_d;
    logic [16:0] addr_d;
    logic [31:0] data_d;
`ifdef AIB_CFG_READBACK_EN
    logic        read_d, err_d;
`else
    logic        unused_readback;
    assign unused_readback = ^{avmm_readdata, avmm_readdatavalid};
    assign avmm_read = 1'b0;
    assign cfg_error = 1'b0;
`endif

    assign avmm_byteenable = 4'hF;
    assign main_edge       = start_main_op & ~start_main_q;
    assign phase_edge      = start_phase_adj & ~start_phase_q;
    // PHASE uses a single register per channel, so reg index 0 is always its last entry.
    assign last_entry      = (chnl_q == LAST_CHNL) && (!op_main_q || reg_q == 2'd2);

    always_comb begin
        state_d      = state_q;
        op_main_d    = op_main_q;
        chnl_d       = chnl_q;
        reg_d        = reg_q;
        write_d      = avmm_write;
        addr_d       = avmm_address;
        data_d       = avmm_writedata;
        main_done_d  = main_op_done;
        phase_done_d = phase_adj_done;
`ifdef AIB_CFG_READBACK_EN
        read_d       = avmm_read;
        err_d        = cfg_error;
`endif
        nxt_chnl     = chnl_q;
        nxt_reg      = 2'd0;
        if (op_main_q && reg_q != 2'd2) begin
            nxt_reg = reg_q + 2'd1;
        end else begin
            nxt_chnl = chnl_q + 6'd1;
        end

        case (state_q)
            S_IDLE: begin
                // MAIN wins when both requests rise together; the PHASE edge is simply lost.
                if (main_edge || phase_edge) begin
                    op_main_d = main_edge;
                    chnl_d    = 6'd0;
                    reg_d     = 2'd0;
                    write_d   = 1'b1;
                    addr_d    = {6'd0, reg_offset(main_edge, 2'd0)};
                    data_d    = reg_data(main_edge, 2'd0);
                    state_d   = S_WR;
                    if (main_edge) main_done_d  = 1'b0;
                    else           phase_done_d = 1'b0;
                end
            end
            S_WR: begin
                if (!avmm_waitrequest) begin
                    write_d = 1'b0;
`ifdef AIB_CFG_READBACK_EN
                    read_d  = 1'b1;
                    state_d = S_RD;
`else
                    state_d = S_GAP;
`endif
                end
            end
`ifdef AIB_CFG_READBACK_EN
            S_RD: begin
                if (!avmm_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (avmm_readdatavalid) begin
                    if (avmm_readdata != avmm_writedata) err_d = 1'b1;
                    state_d = S_GAP;
                end
            end
`endif
            S_GAP: begin
                if (last_entry) begin
                    state_d = S_IDLE;
                    if (op_main_q) main_done_d  = 1'b1;
                    else           phase_done_d = 1'b1;
                end else begin
                    chnl_d  = nxt_chnl;
                    reg_d   = nxt_reg;
                    write_d = 1'b1;
                    addr_d  = {nxt_chnl, reg_offset(op_main_q, nxt_reg)};
                    data_d  = reg_data(op_main_q, nxt_reg);
                    state_d = S_WR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_main_q      <= 1'b0;
            chnl_q         <= 6'd0;
            reg_q          <= 2'd0;
            start_main_q   <= 1'b0;
            start_phase_q  <= 1'b0;
            avmm_write     <= 1'b0;
            avmm_address   <= 17'd0;
            avmm_writedata <= 32'd0;
            main_op_done   <= 1'b0;
            phase_adj_done <= 1'b0;
`ifdef AIB_CFG_READBACK_EN
            avmm_read      <= 1'b0;
            cfg_error      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            op_main_q      <= op_main_d;
            chnl_q         <= chnl_d;
            reg_q          <= reg_d;
            start_main_q   <= start_main_op;
            start_phase_q  <= start_phase_adj;
            avmm_write     <= write_d;
            avmm_address   <= addr_d;
            avmm_writedata <= data_d;
            main_op_done   <= main_done_d;
            phase_adj_done <= phase_done_d;
`ifdef AIB_CFG_READBACK_EN
            avmm_read      <= read_d;
            cfg_error      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_aib_avmm_cfg_sequencer.sv
// Directed bench for aib_avmm_cfg_sequencer: scenario table plus hand sequences for
// held starts, dropped edges, asynchronous reset and (with AIB_CFG_READBACK_EN) readback errors.
module tb_aib_avmm_cfg_sequencer;

`ifdef AIB_CFG_READBACK_EN
    localparam int K = 4;
`else
    localparam int K = 2;
`endif
    localparam logic [31:0] D0 = 32'h0000_0001;
    localparam logic [31:0] D1 = 32'h0000_0100;
    localparam logic [31:0] D2 = 32'h0001_0000;
    localparam logic [31:0] PD = 32'h0000_0003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_main_op = 1'b0;
    logic        start_phase_adj = 1'b0;
    logic        main_op_done, phase_adj_done, avmm_write, avmm_read, cfg_error;
    logic [16:0] avmm_address;
    logic [31:0] avmm_writedata;
    logic [3:0]  avmm_byteenable;
    logic        avmm_waitrequest = 1'b0;
    logic [31:0] avmm_readdata = 32'd0;
    logic        avmm_readdatavalid = 1'b0;

    aib_avmm_cfg_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .start_main_op(start_main_op), .main_op_done(main_op_done),
        .start_phase_adj(start_phase_adj), .phase_adj_done(phase_adj_done),
        .avmm_address(avmm_address), .avmm_writedata(avmm_writedata),
        .avmm_byteenable(avmm_byteenable), .avmm_write(avmm_write), .avmm_read(avmm_read),
        .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
        .avmm_readdatavalid(avmm_readdatavalid), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    // Slave model and write monitor, evaluated on the falling edge.
    int          wr_cnt = 0;
    logic [16:0] wr_addr [0:4095];
    logic [31:0] wr_data [0:4095];
    int          stall_at = -1;
    int          stall_len = 0;
    int          stall_used = 0;
    int          hold_cycles = 0;
    int          stall_bad = 0;
    logic [16:0] hold_addr = '0;
    logic [31:0] hold_data = '0;
    logic [31:0] rd_val = '0;
    bit          rd_pend = 0;
    bit          corrupt_ch5 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            avmm_waitrequest   = 1'b0;
            avmm_readdatavalid = 1'b0;
            rd_pend            = 0;
            stall_used         = 0;
        end else begin
            avmm_readdatavalid = 1'b0;
            if (rd_pend) begin
                avmm_readdatavalid = 1'b1;
                avmm_readdata      = rd_val;
                rd_pend            = 0;
            end
            avmm_waitrequest = 1'b0;
            if (avmm_read) begin
                rd_pend = 1;
                rd_val  = avmm_writedata ^ ((corrupt_ch5 && avmm_address[16:11] == 6'd5) ? 32'h1 : 32'h0);
            end
            if (avmm_write) begin
                if (wr_cnt == stall_at) begin
                    if (stall_used == 0) begin
                        hold_addr = avmm_address;
                        hold_data = avmm_writedata;
                    end else if (avmm_address !== hold_addr || avmm_writedata !== hold_data) begin
                        stall_bad++;
                    end
                    hold_cycles++;
                end
                if (wr_cnt == stall_at && stall_used < stall_len) begin
                    avmm_waitrequest = 1'b1;
                    stall_used++;
                end else begin
                    if (wr_cnt < 4096) begin
                        wr_addr[wr_cnt] = avmm_address;
                        wr_data[wr_cnt] = avmm_writedata;
                    end
                    wr_cnt++;
                    stall_used = 0;
                end
            end
        end
    end

    int vec_cnt = 0;
    int miss_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] exp_addr(input bit is_main, input int i);
        logic [5:0]  ch;
        logic [10:0] off;
        if (is_main) begin
            ch  = 6'(i / 3);
            off = (i % 3 == 0) ? 11'h208 : (i % 3 == 1) ? 11'h20C : 11'h210;
        end else begin
            ch  = 6'(i);
            off = 11'h31C;
        end
        return {ch, off};
    endfunction

    function automatic logic [31:0] exp_data(input bit is_main, input int i);
        if (!is_main) return PD;
        return (i % 3 == 0) ? D0 : (i % 3 == 1) ? D1 : D2;
    endfunction

    // Launch one op, wait (bounded) for its done flag, then release the start line.
    task automatic run_op(input bit m, input bit p, input int st_idx, input int st_len,
                          output int base, output int nw, output int dc, output logic d0);
        base      = wr_cnt;
        stall_at  = (st_idx == 0) ? -1 : base + st_idx - 1;
        stall_len = st_len;
        dc        = -1;
        d0        = 1'bx;
        @(negedge clk);
        start_main_op   = m;
        start_phase_adj = p;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 0) d0 = m ? main_op_done : phase_adj_done;
            if ((m ? main_op_done : phase_adj_done) === 1'b1) begin
                dc = n;
                break;
            end
        end
        start_main_op   = 1'b0;
        start_phase_adj = 1'b0;
        repeat (4) @(negedge clk);
        nw       = wr_cnt - base;
        stall_at = -1;
    endtask

    typedef struct packed {
        logic        m;
        logic        p;
        int          st_idx;
        int          st_len;
        int          exp_nw;
        logic [16:0] f_addr;
        logic [31:0] f_data;
        logic [16:0] l_addr;
        logic [31:0] l_data;
        logic        exp_md;
        logic        exp_pd;
    } vec_t;

    initial begin
        vec_t vecs [0:3];
        int   base, nw, dc, bad, h0, b0, mark;
        logic d0;

        vecs[0] = '{m:1, p:0, st_idx:0,  st_len:0, exp_nw:72, f_addr:17'h00208, f_data:D0,
                    l_addr:17'h0BA10, l_data:D2, exp_md:1, exp_pd:0};
        vecs[1] = '{m:0, p:1, st_idx:0,  st_len:0, exp_nw:24, f_addr:17'h0031C, f_data:PD,
                    l_addr:17'h0BB1C, l_data:PD, exp_md:1, exp_pd:1};
        vecs[2] = '{m:1, p:0, st_idx:2,  st_len:5, exp_nw:72, f_addr:17'h00208, f_data:D0,
                    l_addr:17'h0BA10, l_data:D2, exp_md:1, exp_pd:1};
        vecs[3] = '{m:0, p:1, st_idx:24, st_len:3, exp_nw:24, f_addr:17'h0031C, f_data:PD,
                    l_addr:17'h0BB1C, l_data:PD, exp_md:1, exp_pd:1};

        repeat (3) @(negedge clk);
        check("rst_write", avmm_write, 0);
        check("rst_read", avmm_read, 0);
        check("rst_main_done", main_op_done, 0);
        check("rst_phase_done", phase_adj_done, 0);
        check("rst_byteen", avmm_byteenable, 4'hF);
        check("rst_addr", avmm_address, 0);
        check("rst_wdata", avmm_writedata, 0);
        check("rst_cfg_error", cfg_error, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            h0 = hold_cycles;
            b0 = stall_bad;
            run_op(vecs[v].m, vecs[v].p, vecs[v].st_idx, vecs[v].st_len, base, nw, dc, d0);
            check($sformatf("v%0d_writes", v), nw, vecs[v].exp_nw);
            check($sformatf("v%0d_done_cycle", v), dc, K * vecs[v].exp_nw + vecs[v].st_len);
            check($sformatf("v%0d_done_cleared", v), d0, 0);
            check($sformatf("v%0d_first_addr", v), wr_addr[base], vecs[v].f_addr);
            check($sformatf("v%0d_first_data", v), wr_data[base], vecs[v].f_data);
            check($sformatf("v%0d_last_addr", v), wr_addr[base + vecs[v].exp_nw - 1], vecs[v].l_addr);
            check($sformatf("v%0d_last_data", v), wr_data[base + vecs[v].exp_nw - 1], vecs[v].l_data);
            check($sformatf("v%0d_main_done", v), main_op_done, vecs[v].exp_md);
            check($sformatf("v%0d_phase_done", v), phase_adj_done, vecs[v].exp_pd);
            bad = 0;
            for (int i = 0; i < vecs[v].exp_nw && i < nw; i++)
                if (wr_addr[base + i] !== exp_addr(vecs[v].m, i) || wr_data[base + i] !== exp_data(vecs[v].m, i))
                    bad++;
            check($sformatf("v%0d_order", v), bad, 0);
            if (vecs[v].st_len > 0) begin
                check($sformatf("v%0d_hold_cycles", v), hold_cycles - h0, vecs[v].st_len + 1);
                check($sformatf("v%0d_hold_stable", v), stall_bad - b0, 0);
            end
        end

        // Level-held start runs once only; a fresh edge reruns and clears done immediately.
        base = wr_cnt;
        @(negedge clk);
        start_main_op = 1'b1;
        repeat (300) @(negedge clk);
        check("held_writes", wr_cnt - base, 72);
        check("held_done", main_op_done, 1);
        start_main_op = 1'b0;
        repeat (2) @(negedge clk);
        run_op(1, 0, 0, 0, base, nw, dc, d0);
        check("rerun_done_cleared", d0, 0);
        check("rerun_writes", nw, 72);
        check("rerun_done_cycle", dc, K * 72);

        // MAIN edge during PHASE must be dropped.
        base = wr_cnt;
        @(negedge clk);
        start_phase_adj = 1'b1;
        repeat (10) @(negedge clk);
        start_main_op = 1'b1;
        repeat (3) @(negedge clk);
        start_main_op = 1'b0;
        for (int n = 0; n < 1000 && phase_adj_done !== 1'b1; n++) @(negedge clk);
        start_phase_adj = 1'b0;
        repeat (20) @(negedge clk);
        check("ph_writes", wr_cnt - base, 24);
        check("ph_last_addr", wr_addr[base + 23], 17'h0BB1C);
        check("ph_phase_done", phase_adj_done, 1);
        check("ph_main_done", main_op_done, 1);

        // Simultaneous edges: MAIN runs, PHASE done flag untouched.
        run_op(1, 1, 0, 0, base, nw, dc, d0);
        check("both_writes", nw, 72);
        check("both_first_addr", wr_addr[base], 17'h00208);
        check("both_phase_done", phase_adj_done, 1);
        check("both_main_done", main_op_done, 1);

        // Asynchronous reset mid-sequence aborts without done.
        @(negedge clk);
        start_main_op = 1'b1;
        repeat (20) @(negedge clk);
        start_main_op = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_write", avmm_write, 0);
        check("arst_read", avmm_read, 0);
        check("arst_main_done", main_op_done, 0);
        check("arst_phase_done", phase_adj_done, 0);
        check("arst_byteen", avmm_byteenable, 4'hF);
        check("arst_addr", avmm_address, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mark = wr_cnt;
        repeat (200) @(negedge clk);
        check("arst_no_done", main_op_done, 0);
        check("arst_no_writes", wr_cnt - mark, 0);

`ifdef AIB_CFG_READBACK_EN
        check("rb_err_clear", cfg_error, 0);
        corrupt_ch5 = 1;
        run_op(1, 0, 0, 0, base, nw, dc, d0);
        corrupt_ch5 = 0;
        check("rb_cfg_error", cfg_error, 1);
        check("rb_writes", nw, 72);
        check("rb_done", main_op_done, 1);
        check("rb_done_cycle", dc, K * 72);
`else
        check("no_rb_cfg_error", cfg_error, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
